// File: rtl/xadac_vrf_sched_if.sv
// Issue, writeback and VRF-port bundle between xadac_vrf_sched and its neighbours.
// Default geometry matches xadac_pkg: 32 registers of 64-bit vectors.
interface xadac_vrf_sched_if #(
    parameter int NrWb   = 2,
    parameter int VrfLen = 32,
    parameter int VecW   = 64
);
    localparam int RegW = $clog2(VrfLen);
    localparam int CntW = $clog2(VrfLen + 1);

    logic                          issue_valid;
    logic                          issue_ready;
    logic [2:0][RegW-1:0]          issue_rs;
    logic [2:0]                    issue_rs_used;
    logic [RegW-1:0]               issue_rd;
    logic                          issue_rd_used;
    logic [2:0][RegW-1:0]          vrf_rid;
    logic [NrWb-1:0]               wb_valid;
    logic [NrWb-1:0]               wb_ready;
    logic [NrWb-1:0][RegW-1:0]     wb_id;
    logic [NrWb-1:0][VecW-1:0]     wb_data;
    logic [RegW-1:0]               vrf_wid;
    logic [VecW-1:0]               vrf_wdata;
    logic                          vrf_we;
    logic [VrfLen-1:0]             busy;
    logic [CntW-1:0]               pending;
    logic                          wb_err;

    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_used,
               wb_valid, wb_id, wb_data,
        output issue_ready, vrf_rid, wb_ready, vrf_wid, vrf_wdata, vrf_we,
               busy, pending, wb_err
    );

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_used,
               wb_valid, wb_id, wb_data,
        input  issue_ready, vrf_rid, wb_ready, vrf_wid, vrf_wdata, vrf_we,
               busy, pending, wb_err
    );
endinterface

// File: rtl/xadac_vrf_sched.sv
// VRF issue scoreboard (RAW/WAW stall) plus round-robin arbiter for the single
// VRF write port.

// One scoreboard entry; a set beats a clear in the same cycle.
module xadac_vrf_sched_sb (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)      q <= 1'b0;
        else if (set) q <= 1'b1;
        else if (clr) q <= 1'b0;
    end
endmodule

module xadac_vrf_sched #(
    parameter int NrWb   = 2,
    parameter int VrfLen = 32,
    parameter int VecW   = 64
) (
    input logic            clk,
    input logic            rst,
    xadac_vrf_sched_if.slave bus
);
    localparam int RegW = $clog2(VrfLen);
    localparam int CntW = $clog2(VrfLen + 1);
    localparam int PtrW = (NrWb > 1) ? $clog2(NrWb) : 1;

    logic [VrfLen-1:0] busy_q, set_vec, clr_vec;
    logic              stall, accept, granted, inc, dec;
    logic [PtrW-1:0]   rr_ptr, gidx;
    logic [NrWb-1:0]   grant;
    logic [RegW-1:0]   wid;
    logic [VecW-1:0]   wdata;
    logic [CntW-1:0]   pending_q;
    logic              wb_err_q;

    // Stall looks only at registered busy bits: a same-cycle writeback never unblocks.
    always_comb begin
        stall = bus.issue_rd_used & busy_q[bus.issue_rd];
        for (int i = 0; i < 3; i++)
            stall = stall | (bus.issue_rs_used[i] & busy_q[bus.issue_rs[i]]);
    end

    assign accept = bus.issue_valid & ~stall;

    // Round-robin search starting at rr_ptr, wrapping modulo NrWb.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        granted = 1'b0;
        for (int k = 0; k < NrWb; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NrWb) j = j - NrWb;
            if (!granted && bus.wb_valid[j]) begin
                granted  = 1'b1;
                gidx     = PtrW'(j);
                grant[j] = 1'b1;
            end
        end
    end

    // AND-OR write mux; zero when nothing is granted.
    always_comb begin
        wid   = '0;
        wdata = '0;
        for (int i = 0; i < NrWb; i++) begin
            if (grant[i]) begin
                wid   = wid | bus.wb_id[i];
                wdata = wdata | bus.wb_data[i];
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accept && bus.issue_rd_used) set_vec[bus.issue_rd] = 1'b1;
        if (granted)                     clr_vec[wid]          = 1'b1;
    end

    xadac_vrf_sched_sb u_sb [VrfLen-1:0] (
        .clk (clk),
        .rst (rst),
        .set (set_vec),
        .clr (clr_vec),
        .q   (busy_q)
    );

    // A set only ever lands on a clear bit and a clear only counts on a busy bit,
    // so pending tracks popcount(busy) exactly.
    assign inc = |set_vec;
    assign dec = granted & busy_q[wid];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            pending_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            if (granted)
                rr_ptr <= (int'(gidx) == NrWb - 1) ? '0 : gidx + 1'b1;
            if (granted && !busy_q[wid])
                wb_err_q <= 1'b1;
            case ({inc, dec})
                2'b10:   pending_q <= pending_q + CntW'(1);
                2'b01:   pending_q <= pending_q - CntW'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    assign bus.issue_ready = ~stall;
    assign bus.vrf_rid     = bus.issue_rs;
    assign bus.wb_ready    = grant;
    assign bus.vrf_wid     = wid;
    assign bus.vrf_wdata   = wdata;
    assign bus.vrf_we      = granted;
    assign bus.busy        = busy_q;
    assign bus.pending     = pending_q;
    assign bus.wb_err      = wb_err_q;
endmodule

// File: doc/xadac_vrf_sched.md
# xadac_vrf_sched

Issue scoreboard and writeback arbiter for the xadac vector register file (VRF). It admits one vector instruction per cycle, holding it back while any source or destination register still awaits a writeback (RAW/WAW). It shares the VRF's single write port between `NrWb` functional-unit writeback requesters using round-robin arbitration. It sits between the xadac decoder, the functional units and `xadac_vrf`, and drives all VRF read/write port controls.

## Interface
Parameters:
- `NrWb`, default 2: number of writeback requesters; legal range 1..8.
- `VrfLen`, default `xadac_pkg::VrfLen`: number of VRF entries. `RegIdT` indexes them.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decoder presents an instruction.
- `issue_ready`  out  1  instruction accepted this cycle when `issue_valid & issue_ready`.
- `issue_rs`  in  3×RegIdT  source register ids.
- `issue_rs_used`  in  3  per-source enable; unused sources never stall.
- `issue_rd`  in  RegIdT  destination register id.
- `issue_rd_used`  in  1  instruction writes `issue_rd`.
- `vrf_rid`  out  3×RegIdT  VRF read ids; equal to `issue_rs` combinationally.
- `wb_valid`  in  NrWb  writeback request per requester.
- `wb_ready`  out  NrWb  one-hot grant; at most one bit high.
- `wb_id`  in  NrWb×RegIdT  destination id per requester.
- `wb_data`  in  NrWb×VectorT  write data per requester.
- `vrf_wid`, `vrf_wdata`, `vrf_we`  out  RegIdT/VectorT/1  VRF write port, driven combinationally from the granted requester.
- `busy`  out  VrfLen  scoreboard bit per register.
- `pending`  out  $clog2(VrfLen+1)  count of set busy bits.
- `wb_err`  out  1  sticky; set when a writeback is granted to a register whose busy bit is clear.

## Operation
- Scoreboard: one busy bit per VRF entry.
  - An accepted issue with `issue_rd_used` sets `busy[issue_rd]`.
  - A granted writeback clears `busy[wb_id]`.
- Stall rule: `issue_ready = !(any i: issue_rs_used[i] & busy[issue_rs[i]]) & !(issue_rd_used & busy[issue_rd])`.
  - `issue_ready` is independent of `issue_valid`.
  - `issue_ready` reflects the registered busy state only; a writeback in the current cycle does not unblock the same cycle.
- VRF operands are read combinationally in the accept cycle, so sources are guaranteed written before issue. No bypass.
- Arbiter: round-robin over `wb_valid`.
  - Register `rr_ptr` holds the index after the last grant; the search starts at `rr_ptr` and wraps modulo `NrWb`.
  - On a grant, `rr_ptr` becomes (granted index + 1) mod `NrWb`.
  - With no request, `rr_ptr` holds its value.
- `vrf_we = |wb_ready`. With no grant, `vrf_wid` and `vrf_wdata` are 0.
- Same-cycle issue set and writeback clear:
  - They cannot target the same register, since WAW blocks issue to a busy rd.
  - If they nonetheless coincide (not busy, illegal writeback), the set wins and `wb_err` is raised.
- `pending` is updated as +1 on set, −1 on clear, and net 0 when both occur in the same cycle.
- `wb_err` clears only on reset.

## Timing
- Reset (`rst` high at an edge): all busy bits 0, `pending` = 0, `rr_ptr` = 0, `wb_err` = 0.
  - Outputs during and after reset: `issue_ready` = 1, `wb_ready` = 0 unless requested, `vrf_we` = 0 unless requested.
- Reset mid-operation discards all outstanding scoreboard state; in-flight units must be flushed externally.
- Issue-to-busy latency: 1 cycle. The accept edge sets the bit, and a dependent instruction sees the stall in the next cycle.
- Writeback-to-unblock latency: 1 cycle. The grant edge writes the VRF and clears the bit, and the dependent instruction is accepted in the next cycle and reads the new data.
- Grant latency: 0 cycles. `wb_ready` is combinational from `wb_valid` and `rr_ptr`.
- A requester must hold `wb_valid`, `wb_id` and `wb_data` stable until granted.
- Throughput: 1 issue plus 1 writeback per cycle.

## Test plan
- Reset then idle: `busy` = 0, `pending` = 0, `issue_ready` = 1, `vrf_we` = 0.
- RAW: issue rd=5 accepted; next cycle, issue with rs1=5 → `issue_ready` = 0. Requester 0 writes id 5 with data 0xA5.. → next cycle `issue_ready` = 1, `vrf_rid[1]` = 5, and the VRF returns 0xA5...
- WAW: rd=7 busy; new issue with rd=7 (no sources used) → stalled until wb id 7 is granted, then accepted the next cycle with `busy[7]` = 1 again.
- Round robin, NrWb=2, both valid for 4 cycles with distinct busy ids → grants 0, 1, 0, 1; `pending` decrements each cycle.
- Same cycle: accept issue rd=3 while granting wb id 9 (busy) → `busy[3]` = 1, `busy[9]` = 0, `pending` unchanged.
- Writeback to non-busy id 12 → VRF written, `wb_err` = 1 and stays 1 until `rst`; reset during pending=4 → `pending` = 0 on the next cycle.
